// File: rtl/lat_table_serializer_if.sv
// Handshake and serial-line bundle between a configuration host and lat_table_serializer.
// The host side uses the master modport; the serializer uses the slave modport.
interface lat_table_serializer_if #(
  parameter int WIDTH = 27
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic             abort;
  logic             ser_out;
  logic             ser_strobe;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, data_in, abort,
    input  load_ready, ser_out, ser_strobe, busy, done
  );

  modport slave (
    input  load_valid, data_in, abort,
    output load_ready, ser_out, ser_strobe, busy, done
  );
endinterface

// File: rtl/lat_table_serializer.sv
// Parallel-to-serial feeder for the look-at-table REG_STATE port, MSB first, BIT_DIV clocks per bit.
// Define LAT_SER_PARITY_EN to append an even-parity bit after data bit 0.
module lat_table_serializer #(
  parameter int WIDTH   = 27,
  parameter int BIT_DIV = 1
) (
  input logic                  clk,
  input logic                  reset,
  lat_table_serializer_if.slave bus
);

`ifdef LAT_SER_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      bit_q, bit_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  strobe;

  // Sample point is the last cycle of each bit period; constant-true in SHIFT when BIT_DIV is 1.
  assign strobe = (state_q == SHIFT) && (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load_valid && !bus.abort) begin
`ifdef LAT_SER_PARITY_EN
          shreg_d = {bus.data_in, ^bus.data_in};
`else
          shreg_d = bus.data_in;
`endif
          bit_d   = '0;
          div_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          shreg_d = '0;
          bit_d   = '0;
          div_d   = '0;
          state_d = IDLE;
        end else if (strobe) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          div_d   = '0;
          // Last bit leaves the counter cleared rather than letting it reach FRAME_BITS.
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = DONE;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DONE: begin
        shreg_d = '0;
        bit_d   = '0;
        div_d   = '0;
        state_d = IDLE;
      end
      default: begin
        shreg_d = '0;
        bit_d   = '0;
        div_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.load_ready = (state_q == IDLE);
    bus.busy       = (state_q == SHIFT);
    bus.done       = (state_q == DONE);
    bus.ser_out    = (state_q == SHIFT) && shreg_q[FRAME_BITS-1];
    bus.ser_strobe = strobe;
  end

endmodule
